// File: rtl/simon_autoplayer_if.sv
// simon_autoplayer_if: LED observation, button drive and status bundle for simon_autoplayer.
// force_mistake exists only when SIMON_AUTOPLAYER_MISTAKE_EN is defined.
interface simon_autoplayer_if #(parameter int DEPTH_BITS = 8);
   logic enable;
   logic [2:0] simon_led0, simon_led1, simon_led2, simon_led3;
   logic [3:0] buttons_n;
   logic active, overflow, fault;
   logic [DEPTH_BITS:0] moves;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
   logic force_mistake;
   modport master (output enable, simon_led0, simon_led1, simon_led2, simon_led3, force_mistake,
                   input buttons_n, active, moves, overflow, fault);
   modport slave (input enable, simon_led0, simon_led1, simon_led2, simon_led3, force_mistake,
                  output buttons_n, active, moves, overflow, fault);
`else
   modport master (output enable, simon_led0, simon_led1, simon_led2, simon_led3,
                   input buttons_n, active, moves, overflow, fault);
   modport slave (input enable, simon_led0, simon_led1, simon_led2, simon_led3,
                  output buttons_n, active, moves, overflow, fault);
`endif
endinterface

// File: rtl/simon_autoplayer.sv
// simon_autoplayer: records the moves Simon recites on its LEDs and replays them on active-low buttons.
// Defining SIMON_AUTOPLAYER_MISTAKE_EN adds force_mistake, which fumbles the last press of a replay.
module simon_autoplayer #(
   parameter int DEPTH_BITS = 8,
   parameter int QUIET_CYCLES = 150_000_000,
   parameter int HOLD_CYCLES = 30_000_000,
   parameter int GAP_CYCLES = 20_000_000
) (
   input logic clk,
   input logic reset_n,
   simon_autoplayer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LISTEN, LIT, PRESS, GAP} state_t;
   localparam logic [31:0] QL = 32'(QUIET_CYCLES - 1);
   localparam logic [31:0] HL = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] GL = 32'(GAP_CYCLES - 1);
   state_t state;
   logic [1:0] mem [2**DEPTH_BITS];
   logic [DEPTH_BITS:0] wr_ptr, rd_ptr, rd_nxt;
   logic [31:0] quiet, cnt;
   logic [3:0] lit;
   logic [1:0] idx, cur, nb;
   logic single, multi, commit;
   assign bus.moves = wr_ptr;
   always_comb begin
      lit = {|bus.simon_led3, |bus.simon_led2, |bus.simon_led1, |bus.simon_led0};
      single = lit != 4'd0 && (lit & (lit - 4'd1)) == 4'd0;
      multi = lit != 4'd0 && !single;
      idx = lit[1] ? 2'd1 : lit[2] ? 2'd2 : lit[3] ? 2'd3 : 2'd0;
      commit = bus.enable && state == LIT && !multi && (lit == 4'd0 || idx != cur);
      rd_nxt = state == GAP ? rd_ptr + 1'b1 : '0;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
      nb = mem[rd_nxt[DEPTH_BITS-1:0]] + {1'b0, bus.force_mistake && rd_nxt + 1'b1 == wr_ptr};
`else
      nb = mem[rd_nxt[DEPTH_BITS-1:0]];
`endif
   end
   // A move is stored when its LED goes out (or is replaced), so one write port suffices.
   always_ff @(posedge clk)
      if (commit && !wr_ptr[DEPTH_BITS]) mem[wr_ptr[DEPTH_BITS-1:0]] <= cur;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         bus.buttons_n <= 4'hF;
         bus.active <= 1'b0;
         bus.overflow <= 1'b0;
         bus.fault <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         quiet <= '0;
         cnt <= '0;
         cur <= '0;
      end else if (!bus.enable) begin
         state <= IDLE;
         bus.buttons_n <= 4'hF;
         bus.active <= 1'b0;
         bus.overflow <= 1'b0;
         bus.fault <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         quiet <= '0;
         cnt <= '0;
      end else begin
         if (commit) begin
            wr_ptr <= wr_ptr[DEPTH_BITS] ? wr_ptr : wr_ptr + 1'b1;
            if (wr_ptr[DEPTH_BITS]) bus.overflow <= 1'b1;
            quiet <= '0;
         end
         case (state)
            IDLE: begin
               state <= LISTEN;
               wr_ptr <= '0;
               quiet <= '0;
            end
            LISTEN, LIT:
               if (multi) begin
                  bus.fault <= 1'b1;
                  wr_ptr <= '0;
                  state <= LISTEN;
               end else if (single) begin
                  cur <= idx;
                  state <= LIT;
               end else if (state == LIT) state <= LISTEN;
               else if (wr_ptr != '0) begin
                  if (quiet == QL) begin
                     rd_ptr <= '0;
                     cnt <= '0;
                     bus.active <= 1'b1;
                     bus.buttons_n <= ~(4'b1 << nb);
                     state <= PRESS;
                  end else quiet <= quiet + 32'd1;
               end
            PRESS:
               if (cnt == HL) begin
                  cnt <= '0;
                  bus.buttons_n <= 4'hF;
                  state <= GAP;
               end else cnt <= cnt + 32'd1;
            GAP:
               if (cnt == GL) begin
                  cnt <= '0;
                  rd_ptr <= rd_nxt;
                  if (rd_nxt == wr_ptr) begin
                     wr_ptr <= '0;
                     quiet <= '0;
                     bus.active <= 1'b0;
                     state <= LISTEN;
                  end else begin
                     bus.buttons_n <= ~(4'b1 << nb);
                     state <= PRESS;
                  end
               end else cnt <= cnt + 32'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_simon_autoplayer.sv
// tb_simon_autoplayer: directed stimulus with a per-cycle move-list model plus literal press checks.
module tb_simon_autoplayer;
   localparam int DB = 2, Q = 20, H = 5, G = 3;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [2:0] led [4];
   always #5 clk = ~clk;
   simon_autoplayer_if #(.DEPTH_BITS(DB)) bus ();
   simon_autoplayer #(.DEPTH_BITS(DB), .QUIET_CYCLES(Q), .HOLD_CYCLES(H), .GAP_CYCLES(G))
      dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   assign bus.simon_led0 = led[0];
   assign bus.simon_led1 = led[1];
   assign bus.simon_led2 = led[2];
   assign bus.simon_led3 = led[3];
   int checks = 0, errors = 0;
   int rec[$];
   logic [3:0] sched[$];
   int hold_idx = -1, dark = 0;
   bit on = 0, replay = 0;
   logic [3:0] e_btn = 4'hF;
   logic e_act = 0, e_ovf = 0, e_flt = 0;
   logic [3:0] presses[$];
   int lens[$];
   int run = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      on = 0; replay = 0; rec.delete(); sched.delete(); hold_idx = -1; dark = 0;
      e_btn = 4'hF; e_act = 0; e_ovf = 0; e_flt = 0;
   endtask

   task automatic commit_move();
      if (rec.size() == 2**DB) e_ovf = 1;
      else rec.push_back(hold_idx);
      dark = 0;
   endtask

   task automatic start_replay();
      logic [1:0] m;
      sched.delete();
      foreach (rec[j]) begin
         m = 2'(rec[j]);
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
         if (bus.force_mistake && j == rec.size() - 1) m = m + 2'd1;
`endif
         repeat (H) sched.push_back(4'hF ^ (4'b0001 << m));
         repeat (G) sched.push_back(4'hF);
      end
      replay = 1; e_act = 1; e_btn = sched.pop_front();
   endtask

   task automatic record();
      int n = 0, i = 0;
      for (int k = 0; k < 4; k++) if (led[k] != 3'd0) begin n++; i = k; end
      if (n > 1) begin e_flt = 1; rec.delete(); hold_idx = -1; end
      else if (n == 1) begin
         if (hold_idx >= 0 && hold_idx != i) commit_move();
         hold_idx = i;
      end else if (hold_idx >= 0) begin commit_move(); hold_idx = -1; end
      else if (rec.size() > 0) begin
         dark++;
         if (dark == Q) start_replay();
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n || !bus.enable) model_clear();
      else if (!on) begin on = 1; rec.delete(); hold_idx = -1; dark = 0; end
      else if (replay) begin
         if (sched.size() > 0) e_btn = sched.pop_front();
         else begin replay = 0; e_act = 0; e_btn = 4'hF; rec.delete(); dark = 0; end
      end else record();
   end

   initial forever begin
      @(negedge clk);
      chk("buttons_n", {28'd0, bus.buttons_n}, {28'd0, e_btn});
      chk("active", {31'd0, bus.active}, {31'd0, e_act});
      chk("moves", 32'(bus.moves), rec.size());
      chk("overflow", {31'd0, bus.overflow}, {31'd0, e_ovf});
      chk("fault", {31'd0, bus.fault}, {31'd0, e_flt});
      if (bus.buttons_n !== 4'hF) begin
         if (run == 0) presses.push_back(bus.buttons_n);
         run++;
      end else if (run > 0) begin lens.push_back(run); run = 0; end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int k, input int on_c, input int off_c);
      led[k] = 3'b100; cyc(on_c); led[k] = 3'b000; cyc(off_c);
   endtask

   task automatic wait_done(input string name, input int budget);
      int t = 0;
      while (!bus.active && t < budget) begin cyc(1); t++; end
      while (bus.active && t < budget) begin cyc(1); t++; end
      chk(name, t < budget, 1);
   endtask

   task automatic chk_presses(input string name, input int n, input logic [15:0] exp);
      chk({name, "_count"}, presses.size(), n);
      for (int k = 0; k < n; k++)
         chk(name, {28'd0, k < presses.size() ? presses[k] : 4'hx}, {28'd0, exp[4*k +: 4]});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 4; k++) led[k] = 3'd0;
      bus.enable = 1'b0;
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
      bus.force_mistake = 1'b0;
`endif
      cyc(3);
      chk("rst_buttons", {28'd0, bus.buttons_n}, 32'hF);
      chk("rst_active", {31'd0, bus.active}, 0);
      chk("rst_moves", 32'(bus.moves), 0);
      chk("rst_overflow", {31'd0, bus.overflow}, 0);
      chk("rst_fault", {31'd0, bus.fault}, 0);
      reset_n = 1'b1; bus.enable = 1'b1;
      presses.delete();
      cyc(100);
      chk("dark_no_press", presses.size(), 0);
      // three-move recital then replay
      presses.delete(); lens.delete();
      pulse(2, 4, 4); pulse(0, 4, 4); pulse(3, 4, 4);
      chk("three_moves", 32'(bus.moves), 3);
      wait_done("three_replay_done", 200);
      chk_presses("three_press", 3, {4'h0, 4'b0111, 4'b1110, 4'b1011});
      chk("three_hold_lens", lens.size(), 3);
      foreach (lens[k]) chk("three_hold_len", lens[k], H);
      chk("three_end_moves", 32'(bus.moves), 0);
      chk("three_end_active", {31'd0, bus.active}, 0);
      // failure strobe wipes a partial recording
      presses.delete();
      pulse(1, 4, 4);
      for (int k = 0; k < 4; k++) led[k] = 3'b111;
      cyc(2);
      for (int k = 0; k < 4; k++) led[k] = 3'b000;
      cyc(40);
      chk("strobe_fault", {31'd0, bus.fault}, 1);
      chk("strobe_moves", 32'(bus.moves), 0);
      chk("strobe_no_press", presses.size(), 0);
      // enable drop mid-replay
      bus.enable = 1'b0; cyc(2); bus.enable = 1'b1; cyc(2);
      chk("toggle_clears_fault", {31'd0, bus.fault}, 0);
      presses.delete();
      pulse(1, 4, 4); pulse(2, 4, 4); pulse(3, 4, 4);
      for (int t = 0; t < 300 && presses.size() < 2; t++) cyc(1);
      chk("second_press_seen", presses.size(), 2);
      cyc(2);
      bus.enable = 1'b0; cyc(1);
      chk("drop_buttons", {28'd0, bus.buttons_n}, 32'hF);
      chk("drop_active", {31'd0, bus.active}, 0);
      bus.enable = 1'b1; cyc(40);
      chk("drop_moves", 32'(bus.moves), 0);
      chk("drop_no_more_press", presses.size(), 2);
      // overflow with a four-entry memory
      presses.delete();
      pulse(0, 3, 3); pulse(1, 3, 3); pulse(2, 3, 3); pulse(3, 3, 3); pulse(0, 3, 3);
      chk("ovf_flag", {31'd0, bus.overflow}, 1);
      chk("ovf_moves", 32'(bus.moves), 4);
      wait_done("ovf_replay_done", 300);
      chk_presses("ovf_press", 4, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
      // LED handed straight from led1 to led2
      presses.delete();
      led[1] = 3'b010; cyc(4); led[1] = 3'b000; led[2] = 3'b010; cyc(4); led[2] = 3'b000; cyc(2);
      chk("switch_moves", 32'(bus.moves), 2);
      wait_done("switch_replay_done", 200);
      chk_presses("switch_press", 2, {8'h00, 4'b1011, 4'b1101});
`ifdef SIMON_AUTOPLAYER_MISTAKE_EN
      bus.force_mistake = 1'b1;
      presses.delete();
      pulse(1, 4, 4); pulse(3, 4, 4);
      wait_done("mistake_replay_done", 200);
      chk_presses("mistake_press", 2, {8'h00, 4'b1110, 4'b1101});
      bus.force_mistake = 1'b0;
`endif
      cyc(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
